// File: rtl/key_counter_ctrl.sv
// Push-button controlled 8-LED binary counter.
// Keys are synchronized and debounced, then turned into one-cycle press events.
// Those events drive a mode FSM (run up / run down / paused-step), a rate index
// and a shared prescaler.
module key_counter_ctrl #(
   parameter int unsigned COUNT_W    = 8,
   parameter int unsigned DEBOUNCE_W = 16,
   parameter int unsigned PRESC_W    = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2:0]         key,
   output logic [COUNT_W-1:0] led,
   output logic [COUNT_W-1:0] count,
   output logic [1:0]         mode,
   output logic [1:0]         speed,
   output logic               tick
);

   typedef enum logic [1:0] {
      StRunUp   = 2'd0,
      StRunDown = 2'd1,
      StPause   = 2'd2,
      StBad     = 2'd3
   } mode_e;

   // Key path: two-flop synchronizer, debounce, registered press detect.
   logic [2:0]            sync1_q, sync2_q;
   logic [2:0]            stable_q, stable_d;
   logic [2:0]            stable_dly_q;
   logic [2:0]            evt_q;
   logic [DEBOUNCE_W-1:0] db_cnt_q [3];
   logic [DEBOUNCE_W-1:0] db_cnt_d [3];

   // Counter / FSM state.
   logic [COUNT_W-1:0]    count_q, count_d;
   mode_e                 mode_q, mode_d;
   logic [1:0]            speed_q, speed_d;
   logic [PRESC_W-1:0]    presc_q, presc_d;
   logic [PRESC_W-1:0]    presc_mask;
   logic                  run_state;
   logic                  clear_evt, speed_evt, mode_evt;

   assign clear_evt = evt_q[0];
   assign speed_evt = evt_q[1];
   assign mode_evt  = evt_q[2];

   // Debounce: accept the synced value once it has differed for 2**DEBOUNCE_W cycles.
   always_comb begin
      stable_d = stable_q;
      db_cnt_d = db_cnt_q;
      for (int i = 0; i < 3; i++) begin
         if (sync2_q[i] == stable_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == {DEBOUNCE_W{1'b1}}) begin
            stable_d[i] = sync2_q[i];
            db_cnt_d[i] = '0;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + DEBOUNCE_W'(1);
         end
      end
   end

   // Key path registers; released keys read as 1, so reset to 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q      <= '1;
         sync2_q      <= '1;
         stable_q     <= '1;
         stable_dly_q <= '1;
         evt_q        <= '0;
         db_cnt_q     <= '{default: '0};
      end else begin
         sync1_q      <= key;
         sync2_q      <= sync1_q;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         evt_q        <= stable_dly_q & ~stable_q;
         db_cnt_q     <= db_cnt_d;
      end
   end

   // Tick when the low (PRESC_W - 2*speed) prescaler bits are all ones while running.
   always_comb begin
      run_state  = (mode_q == StRunUp) || (mode_q == StRunDown);
      presc_mask = {PRESC_W{1'b1}} >> {speed_q, 1'b0};
      tick       = run_state && ((presc_q & presc_mask) == presc_mask);
   end

   // Next state: clear beats mode beats speed; clear also masks the tick step.
   always_comb begin
      count_d = count_q;
      mode_d  = mode_q;
      speed_d = speed_q;
      presc_d = run_state ? presc_q + PRESC_W'(1) : '0;
      if (mode_q == StBad) begin
         mode_d = StRunUp;
      end
      if (clear_evt) begin
         count_d = '0;
         presc_d = '0;
      end else begin
         if (tick) begin
            count_d = (mode_q == StRunUp) ? count_q + COUNT_W'(1) : count_q - COUNT_W'(1);
         end
         if (mode_evt) begin
            case (mode_q)
               StRunUp:   mode_d = StRunDown;
               StRunDown: mode_d = StPause;
               default:   mode_d = StRunUp;
            endcase
            presc_d = '0;
         end else if (speed_evt) begin
            if (run_state) begin
               speed_d = speed_q + 2'd1;
               presc_d = '0;
            end else begin
               // Paused: the speed key single-steps the counter instead.
               count_d = count_q + COUNT_W'(1);
            end
         end
      end
   end

   // Counter / FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         mode_q  <= StRunUp;
         speed_q <= '0;
         presc_q <= '0;
      end else begin
         count_q <= count_d;
         mode_q  <= mode_d;
         speed_q <= speed_d;
         presc_q <= presc_d;
      end
   end

   assign count = count_q;
   assign led   = ~count_q;
   assign mode  = mode_q;
   assign speed = speed_q;

endmodule

// File: tb/tb_key_counter_ctrl.sv
// Bench for key_counter_ctrl: directed scenarios plus random key activity,
// every cycle compared against a behavioural model of the controller.
module tb_key_counter_ctrl;

   localparam int CW = 8;
   localparam int DW = 2;
   localparam int PW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [2:0]    key = 3'b111;
   logic [CW-1:0] led, count;
   logic [1:0]    mode, speed;
   logic          tick;

   key_counter_ctrl #(
      .COUNT_W   (CW),
      .DEBOUNCE_W(DW),
      .PRESC_W   (PW)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .key  (key),
      .led  (led),
      .count(count),
      .mode (mode),
      .speed(speed),
      .tick (tick)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: keys become presses after a run of 2**DW differing synced
   // samples; counter rules computed with plain modular arithmetic.
   int       m_count, m_mode, m_speed, m_presc;
   int       m_run [3];
   bit [2:0] m_raw1, m_raw2, m_stable, m_fell, m_evt;
   bit       m_valid = 1'b0;

   function automatic int m_tick();
      int period;
      period = 1 << (PW - 2 * m_speed);
      return ((m_mode < 2) && ((m_presc % period) == period - 1)) ? 1 : 0;
   endfunction

   task automatic model_step();
      int tk;
      bit running;
      if (rst) begin
         m_count = 0; m_mode = 0; m_speed = 0; m_presc = 0;
         m_raw1 = 3'b111; m_raw2 = 3'b111; m_stable = 3'b111;
         m_fell = 3'b000; m_evt = 3'b000;
         for (int k = 0; k < 3; k++) m_run[k] = 0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         tk = m_tick();
         running = (m_mode < 2);
         if (m_evt[0]) begin
            m_count = 0;
            m_presc = 0;
         end else begin
            m_presc = running ? (m_presc + 1) % (1 << PW) : 0;
            if (tk != 0) m_count = (m_count + ((m_mode == 0) ? 1 : 255)) % 256;
            if (m_evt[2]) begin
               m_mode  = (m_mode + 1) % 3;
               m_presc = 0;
            end else if (m_evt[1]) begin
               if (running) begin
                  m_speed = (m_speed + 1) % 4;
                  m_presc = 0;
               end else begin
                  m_count = (m_count + 1) % 256;
               end
            end
         end
         m_evt  = m_fell;
         m_fell = 3'b000;
         for (int k = 0; k < 3; k++) begin
            if (m_raw2[k] == m_stable[k]) begin
               m_run[k] = 0;
            end else begin
               m_run[k]++;
               if (m_run[k] == (1 << DW)) begin
                  m_stable[k] = m_raw2[k];
                  m_run[k]    = 0;
                  m_fell[k]   = ~m_raw2[k];
               end
            end
         end
         m_raw2 = m_raw1;
         m_raw1 = key;
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         check("count", count, m_count);
         check("led", led, (~m_count) & 255);
         check("mode", mode, m_mode);
         check("speed", speed, m_speed);
         check("tick", tick, m_tick());
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int k);
      key[k] = 1'b0;
      cyc(10);
      key[k] = 1'b1;
      cyc(10);
   endtask

   int nt;
   int sp;
   int hold;

   initial begin
      // 1. Reset, then 256 cycles in RUN_UP at speed 0.
      cyc(3);
      check("rst_count", count, 0);
      check("rst_led", led, 8'hFF);
      check("rst_mode", mode, 0);
      check("rst_speed", speed, 0);
      check("rst_tick", tick, 0);
      rst = 1'b0;
      nt = 0;
      for (int i = 0; i < 256; i++) begin
         if (tick) nt++;
         cyc(1);
      end
      check("p1_ticks", nt, 1);
      check("p1_count", count, 1);
      check("p1_led", led, 8'hFE);

      // 2. Three speed presses, each taking effect 8 cycles after key low.
      for (int p = 0; p < 3; p++) begin
         sp = speed;
         key[1] = 1'b0;
         cyc(7);
         check("spd_before", speed, sp);
         cyc(1);
         check("spd_after", speed, (sp + 1) % 4);
         cyc(12);
         key[1] = 1'b1;
         cyc(12);
      end
      check("spd_3", speed, 3);
      nt = 0;
      for (int i = 0; i < 16; i++) begin
         if (tick) nt++;
         cyc(1);
      end
      check("p2_ticks16", nt, 4);
      key[1] = 1'b0;
      cyc(3);
      key[1] = 1'b1;
      cyc(20);
      check("glitch_speed", speed, 3);

      // 3. Back to speed 0, clear, RUN_DOWN wraps 0 -> 255, then PAUSE.
      press(1);
      check("spd_wrap", speed, 0);
      press(0);
      press(2);
      check("p3_mode_down", mode, 1);
      check("p3_count0", count, 0);
      cyc(250);
      check("p3_count255", count, 255);
      check("p3_led00", led, 8'h00);
      press(2);
      check("p3_mode_pause", mode, 2);
      nt = 0;
      for (int i = 0; i < 1000; i++) begin
         if (tick) nt++;
         cyc(1);
      end
      check("p3_pause_ticks", nt, 0);
      check("p3_pause_count", count, 255);

      // 4. Single-step in PAUSE.
      press(0);
      for (int i = 0; i < 10; i++) press(1);
      check("p4_count10", count, 10);
      press(1);
      press(1);
      check("p4_count12", count, 12);
      check("p4_speed", speed, 0);

      // 5. Clear and mode events together, landing on a tick cycle.
      press(2);
      check("p5_mode_up", mode, 0);
      cyc(236);
      key = 3'b010;
      cyc(7);
      check("p5_pend_tick", tick, 1);
      cyc(1);
      key = 3'b111;
      check("p5_count", count, 0);
      check("p5_mode", mode, 0);
      nt = 0;
      for (int i = 0; i < 255; i++) begin
         if (tick) nt++;
         cyc(1);
      end
      check("p5_no_tick", nt, 0);
      check("p5_tick_255", tick, 1);

      // 6. Reset in the middle of a mode-key debounce.
      key[2] = 1'b0;
      cyc(4);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      check("p6_count", count, 0);
      check("p6_led", led, 8'hFF);
      check("p6_mode", mode, 0);
      check("p6_speed", speed, 0);
      check("p6_tick", tick, 0);
      cyc(7);
      check("p6_no_evt", mode, 0);
      cyc(1);
      check("p6_evt", mode, 1);
      key = 3'b111;
      cyc(20);

      // Random key activity with occasional reset.
      for (int i = 0; i < 400; i++) begin
         key  = 3'($urandom_range(0, 7));
         hold = $urandom_range(1, 12);
         cyc(hold);
         if ($urandom_range(0, 40) == 0) begin
            rst = 1'b1;
            cyc(1);
            rst = 1'b0;
         end
      end
      key = 3'b111;
      cyc(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/key_counter_ctrl.md
Name: key_counter_ctrl

Overview:
Controller that sequences the board's 8-LED binary counter from the three push-buttons. It synchronizes and debounces the raw keys, runs a mode FSM (count up / count down / paused-step), and selects the count rate through a shared prescaler. It drives the active-low LED bank directly and sits between the board top and the keys/LEDs.

Parameters:
COUNT_W, 8, counter and LED width
DEBOUNCE_W, 16, debounce counter width; a key must be stable for 2**DEBOUNCE_W cycles to be accepted
PRESC_W, 24, prescaler width; must be >= 8

Ports:
clk  input  1  board clock
rst  input  1  synchronous reset, active-high
key  input  3  raw keys, active-low (0 = pressed); key[2] = mode, key[1] = speed/step, key[0] = clear
led  output COUNT_W  active-low LED drive; equals ~count
count  output COUNT_W  current counter value
mode  output 2  FSM state: 0 = RUN_UP, 1 = RUN_DOWN, 2 = PAUSE
speed  output 2  rate index 0..3
tick  output 1  one-cycle pulse when the prescaler expires in a RUN state

Behaviour:
- Reset values: count = 0, led = all ones, mode = RUN_UP, speed = 0, tick = 0, prescaler = 0. Synchronizers and debounced key states reset to 1 (released); event pulses reset to 0.
- Synchronizer: two flops per key.
- Debounce, per key:
  - A DEBOUNCE_W-bit counter clears whenever the synced value equals the stable value.
  - Otherwise it increments each cycle.
  - When the counter equals its all-ones value and the values still differ, stable <= synced and the counter clears.
- Press event: registered one-cycle pulse on a stable 1 -> 0 transition. A held key produces exactly one event. Releases produce no event.
- Latency: a key held low from edge 0 gives an event high during the cycle after edge 2**DEBOUNCE_W + 3. A glitch shorter than 2**DEBOUNCE_W cycles gives no event.
- Event priority within a cycle: clear > mode > speed.
- clear_evt:
  - count <= 0 and prescaler <= 0.
  - mode and speed are unchanged.
  - Suppresses any tick update in the same cycle, and suppresses mode/speed events in the same cycle.
- mode_evt:
  - Transitions RUN_UP -> RUN_DOWN -> PAUSE -> RUN_UP.
  - prescaler <= 0.
  - The speed event in the same cycle is ignored.
- speed_evt in RUN_UP or RUN_DOWN: speed <= speed + 1, wrapping 3 -> 0; prescaler <= 0.
- speed_evt in PAUSE: count <= count + 1 (single step); speed is unchanged.
- Prescaler:
  - Free-running PRESC_W-bit up counter in RUN states; held at 0 in PAUSE.
  - tick is combinational and high when the low (PRESC_W - 2*speed) prescaler bits are all ones in a RUN state.
  - Period = 2**(PRESC_W - 2*speed) cycles.
- On tick: RUN_UP gives count + 1, RUN_DOWN gives count - 1, both modulo 2**COUNT_W (255 -> 0, 0 -> 255). count updates on the same edge at which tick is high.
- led = ~count, combinational from the count register. No extra latency.
- mode value 3 is unreachable; if entered, the next cycle goes to RUN_UP.
- rst asserted mid-operation returns all state to reset values on that edge, including in-flight debounce counters. No event fires on the cycle rst deasserts.

Test Plan:
(Bench parameters: DEBOUNCE_W = 2, PRESC_W = 8.)
1. Reset, then run 256 cycles in RUN_UP at speed 0 -> exactly 1 tick, at prescaler = 255; count = 1; led = 8'hFE.
2. Hold key[1] low for 20 cycles, three times -> exactly 3 events, each 7 cycles after key low; speed = 3; tick period = 4 cycles; glitch of 3 cycles low -> no event.
3. From count = 0, press key[2] once (RUN_DOWN), wait one tick -> count = 255, led = 8'h00; press key[2] again -> mode = PAUSE, no ticks for 1000 cycles.
4. In PAUSE with count = 10, press key[1] twice -> count = 12; speed unchanged.
5. Force key[0] and key[2] events in the same cycle with a pending tick -> count = 0, mode unchanged, prescaler = 0.
6. Assert rst for 1 cycle mid-debounce, with key[2] low for 4 cycles -> all outputs back to reset values; with key held low throughout, no event before 7 cycles after rst deasserts.
